// File: rtl/sram_stream_ctrl.sv
// Command-driven burst controller in front of a dual-port SRAM with a shared write enable.
// Writes are packed into two-word commits; reads fetch two words and stream them one per handshake.
module sram_stream_ctrl #(
    parameter int SIZE       = 300,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  err,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    output logic [ADDR_WIDTH-1:0] mem_addr2,
    output logic [DATA_WIDTH-1:0] mem_din1,
    output logic [DATA_WIDTH-1:0] mem_din2,
    input  logic [DATA_WIDTH-1:0] mem_dout1,
    input  logic [DATA_WIDTH-1:0] mem_dout2
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR0, S_WR1, S_WCOMMIT, S_RFETCH, S_REMIT0, S_REMIT1, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH+1:0] SIZE_W = (ADDR_WIDTH+2)'(SIZE);

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [DATA_WIDTH-1:0] hold0;
    logic [DATA_WIDTH-1:0] hold1;
    logic                  pair;
    logic                  err_q;

    logic [ADDR_WIDTH+1:0] end_addr;
    logic                  two_left;
    logic [ADDR_WIDTH:0]   adv;
    logic [ADDR_WIDTH-1:0] ptr_next1;

    // Range check is done two bits wider than the address so the sum cannot wrap.
    assign end_addr  = {2'b00, cmd_addr} + {1'b0, cmd_len};
    assign two_left  = remaining > (ADDR_WIDTH+1)'(1);
    assign ptr_next1 = ptr + ADDR_WIDTH'(1);

    always_comb begin
        adv = (ADDR_WIDTH+1)'(1);
        if (state == S_RFETCH) begin
            if (two_left) adv = (ADDR_WIDTH+1)'(2);
        end else if (pair) begin
            adv = (ADDR_WIDTH+1)'(2);
        end
    end

    // NOTE: state and data registers use non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            remaining <= '0;
            hold0     <= '0;
            hold1     <= '0;
            pair      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        ptr       <= cmd_addr;
                        remaining <= cmd_len;
                        err_q     <= 1'b0;
                        if (cmd_len == '0) begin
                            state <= S_DONE;
                        end else if (end_addr > SIZE_W) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= cmd_write ? S_WR0 : S_RFETCH;
                        end
                    end
                end
                S_WR0: begin
                    if (wd_valid) begin
                        hold0 <= wd_data;
                        pair  <= two_left;
                        state <= two_left ? S_WR1 : S_WCOMMIT;
                    end
                end
                S_WR1: begin
                    if (wd_valid) begin
                        hold1 <= wd_data;
                        state <= S_WCOMMIT;
                    end
                end
                S_WCOMMIT: begin
                    ptr       <= ptr + adv[ADDR_WIDTH-1:0];
                    remaining <= remaining - adv;
                    state     <= (remaining == adv) ? S_DONE : S_WR0;
                end
                S_RFETCH: begin
                    hold0     <= mem_dout1;
                    hold1     <= mem_dout2;
                    pair      <= two_left;
                    ptr       <= ptr + adv[ADDR_WIDTH-1:0];
                    remaining <= remaining - adv;
                    state     <= S_REMIT0;
                end
                S_REMIT0: begin
                    if (rd_ready) state <= pair ? S_REMIT1 : S_DONE;
                end
                S_REMIT1: begin
                    if (rd_ready) state <= (remaining == '0) ? S_DONE : S_RFETCH;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded purely from registered state; only mem_we also sees rst
    // so that no SRAM write can land in a reset cycle.
    always_comb begin
        cmd_ready = 1'b0;
        wd_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        done      = 1'b0;
        err       = 1'b0;
        mem_we    = 1'b0;
        mem_addr1 = '0;
        mem_addr2 = '0;
        mem_din1  = '0;
        mem_din2  = '0;
        case (state)
            S_IDLE:  cmd_ready = 1'b1;
            S_WR0,
            S_WR1:   wd_ready  = 1'b1;
            S_WCOMMIT: begin
                mem_we    = !rst;
                mem_addr1 = ptr;
                mem_din1  = hold0;
                mem_addr2 = pair ? ptr_next1 : ptr;
                mem_din2  = pair ? hold1 : hold0;
            end
            S_RFETCH: begin
                mem_addr1 = ptr;
                mem_addr2 = two_left ? ptr_next1 : ptr;
            end
            S_REMIT0: begin
                rd_valid = 1'b1;
                rd_data  = hold0;
            end
            S_REMIT1: begin
                rd_valid = 1'b1;
                rd_data  = hold1;
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// Directed bench for sram_stream_ctrl with a behavioural dual-port SRAM and a read-data scoreboard.
module tb_sram_stream_ctrl;
    localparam int SIZE = 300;
    localparam int DW   = 32;
    localparam int AW   = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic          rd_valid, rd_ready;
    logic [DW-1:0] rd_data;
    logic          done, err, mem_we;
    logic [AW-1:0] mem_addr1, mem_addr2;
    logic [DW-1:0] mem_din1, mem_din2, mem_dout1, mem_dout2;

    sram_stream_ctrl #(.SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err), .mem_we(mem_we),
        .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
        .mem_din1(mem_din1), .mem_din2(mem_din2),
        .mem_dout1(mem_dout1), .mem_dout2(mem_dout2)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: combinational reads, both ports written on a shared enable.
    logic [DW-1:0] mem [0:1023];
    assign mem_dout1 = mem[mem_addr1];
    assign mem_dout2 = mem[mem_addr2];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr1] <= mem_din1;
            mem[mem_addr2] <= mem_din2;
        end
    end

    logic [DW-1:0] model [0:1023];
    logic [DW-1:0] wdata [0:15];
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] log_a1 [$];
    logic [AW-1:0] log_a2 [$];
    logic [DW-1:0] log_d1 [$];
    logic [DW-1:0] log_d2 [$];

    int n_pass = 0;
    int n_total = 0;
    int we_cnt = 0, done_cnt = 0, err_cnt = 0, rd_cnt = 0, rv_cnt = 0;
    int lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("we_in_reset", 32'(mem_we), 32'd0);
        end else begin
            if (mem_we) begin
                we_cnt++;
                log_a1.push_back(mem_addr1);
                log_a2.push_back(mem_addr2);
                log_d1.push_back(mem_din1);
                log_d2.push_back(mem_din2);
                check("we_addr2_in_range", 32'(mem_addr2 < AW'(SIZE)), 32'd1);
            end
            if (done) begin
                done_cnt++;
                if (err) err_cnt++;
            end
            if (rd_valid) rv_cnt++;
            if (rd_valid && rd_ready) begin
                rd_cnt++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $error("FAIL rd_unexpected: observed %0h expected no word", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_a1.delete(); log_a2.delete(); log_d1.delete(); log_d2.delete();
    endtask

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [AW:0] l);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                step();
                cmd_valid = 1'b0;
                return;
            end
            step();
        end
        cmd_valid = 1'b0;
        n_total++;
        $error("FAIL cmd_accept_timeout: observed cmd_ready=0 expected 1");
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        wd_valid = 1'b1; wd_data = d;
        for (int i = 0; i < 50; i++) begin
            if (wd_ready) begin
                step();
                wd_valid = 1'b0;
                return;
            end
            step();
        end
        wd_valid = 1'b0;
        n_total++;
        $error("FAIL wd_timeout: observed wd_ready=0 expected 1");
    endtask

    task automatic wait_done(input string tag, input logic exp_err, output int cycles);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                check({tag, "_err"}, 32'(err), 32'(exp_err));
                step();
                return;
            end
            step();
            cycles++;
        end
        n_total++;
        $error("FAIL %s_done_timeout: observed done=0 expected 1", tag);
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input int l, input int stall_after,
                               input string tag);
        int w0;
        send_cmd(1'b1, a, (AW+1)'(l));
        for (int i = 0; i < l; i++) begin
            model[int'(a) + i] = wdata[i];
            push_word(wdata[i]);
            if (i == stall_after) begin
                w0 = we_cnt;
                wd_valid = 1'b0;
                repeat (3) step();
                check({tag, "_stall_no_we"}, 32'(we_cnt - w0), 32'd0);
            end
        end
        wait_done(tag, 1'b0, lat);
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int l, input string tag);
        for (int i = 0; i < l; i++) exp_q.push_back(model[int'(a) + i]);
        rd_ready = 1'b1;
        send_cmd(1'b0, a, (AW+1)'(l));
        wait_done(tag, 1'b0, lat);
        rd_ready = 1'b0;
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, d0, e0, r0, v0;
        logic [DW-1:0] held, old40, old41;

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
        step(); step();

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_ctrl_outs", 32'({wd_ready, rd_valid, done, err, mem_we}), 32'd0);
        check("rst_mem_outs", 32'(mem_addr1 | mem_addr2) | mem_din1 | mem_din2 | rd_data, 32'd0);
        rst = 1'b0;
        step();

        // Paired write then read back.
        wdata[0] = 32'hA0; wdata[1] = 32'hA1; wdata[2] = 32'hA2; wdata[3] = 32'hA3;
        clear_logs();
        w0 = we_cnt; d0 = done_cnt; e0 = err_cnt;
        write_burst(10'd4, 4, -1, "pw");
        check("pw_we_cycles", 32'(we_cnt - w0), 32'd2);
        check("pw_c0_addrs", 32'({log_a1[0], log_a2[0]}), 32'({10'd4, 10'd5}));
        check("pw_c1_addrs", 32'({log_a1[1], log_a2[1]}), 32'({10'd6, 10'd7}));
        check("pw_c1_din2", log_d2[1], 32'hA3);
        read_burst(10'd4, 4, "pr");
        check("pw_done_count", 32'(done_cnt - d0), 32'd2);
        check("pw_err_count", 32'(err_cnt - e0), 32'd0);

        // Odd length: single-word tail writes the same word on both ports.
        wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33;
        clear_logs();
        write_burst(10'd10, 3, -1, "ow");
        check("ow_tail_addrs", 32'({log_a1[1], log_a2[1]}), 32'({10'd12, 10'd12}));
        check("ow_tail_din1", log_d1[1], 32'h33);
        check("ow_tail_din2", log_d2[1], 32'h33);
        read_burst(10'd10, 3, "or");

        // Range error: no SRAM write and no read data.
        w0 = we_cnt; v0 = rv_cnt;
        send_cmd(1'b0, 10'd299, 11'd2);
        wait_done("range", 1'b1, lat);
        check("range_latency", 32'(lat), 32'd0);
        check("range_no_we", 32'(we_cnt - w0), 32'd0);
        check("range_no_rd_valid", 32'(rv_cnt - v0), 32'd0);

        // Top word is legal and the second port never leaves the array.
        wdata[0] = 32'h5A;
        clear_logs();
        write_burst(10'd299, 1, -1, "top");
        check("top_addrs", 32'({log_a1[0], log_a2[0]}), 32'({10'd299, 10'd299}));
        read_burst(10'd299, 1, "topr");

        // Zero length completes with no access.
        w0 = we_cnt; v0 = rv_cnt;
        send_cmd(1'b1, 10'd50, 11'd0);
        wait_done("zero", 1'b0, lat);
        check("zero_no_access", 32'((we_cnt - w0) + (rv_cnt - v0)), 32'd0);

        // Read backpressure.
        wdata[0] = 32'hB0; wdata[1] = 32'hB1;
        write_burst(10'd100, 2, -1, "bw");
        exp_q.push_back(model[100]); exp_q.push_back(model[101]);
        r0 = rd_cnt;
        rd_ready = 1'b0;
        send_cmd(1'b0, 10'd100, 11'd2);
        for (int i = 0; i < 10 && !rd_valid; i++) step();
        held = rd_data;
        check("bp_first_word", held, 32'hB0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", 32'(rd_valid), 32'd1);
            check("bp_data_stable", rd_data, held);
            step();
        end
        rd_ready = 1'b1;
        wait_done("bp", 1'b0, lat);
        rd_ready = 1'b0;
        check("bp_words", 32'(rd_cnt - r0), 32'd2);

        // Write-data stall inside a pair.
        wdata[0] = 32'hC0; wdata[1] = 32'hC1; wdata[2] = 32'hC2; wdata[3] = 32'hC3;
        write_burst(10'd20, 4, 0, "st");
        read_burst(10'd20, 4, "str");

        // Reset during a commit.
        old40 = mem[40]; old41 = mem[41];
        d0 = done_cnt;
        send_cmd(1'b1, 10'd40, 11'd4);
        push_word(32'hD0);
        push_word(32'hD1);
        check("rm_commit_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rm_we_gated", 32'(mem_we), 32'd0);
        step();
        rst = 1'b0;
        check("rm_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rm_outs_idle", 32'({wd_ready, rd_valid, done, mem_we}), 32'd0);
        check("rm_mem40", mem[40], old40);
        check("rm_mem41", mem[41], old41);
        repeat (3) step();
        check("rm_no_done", 32'(done_cnt - d0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
